instr_fetch_unit: RTL

Initiator side of the instruction-memory read interface. Owns the program counter (PC), drives a byte address to the instruction memory, and captures the returned combinational 16-bit word into an instruction register (IR) for the decode stage. Supports stall, branch/jump redirect with flush, halt-word detection and address-range faulting. Sits between the instruction memory and the datapath decode/control logic.

---
 rtl/instr_fetch_unit_if.sv | 25 ++
 rtl/instr_fetch_unit.sv | 123 ++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit_if.sv
// Instruction fetch bus: memory address/data, decode-side control and
// the captured instruction handed to decode.
interface instr_fetch_unit_if;
    logic        run;
    logic [15:0] instrAddr;
    logic [15:0] instrData;
    logic        stall;
    logic        redirect;
    logic [15:0] redirectAddr;
    logic [15:0] ir;
    logic [15:0] irPc;
    logic        irValid;
    logic        halted;
    logic        addrFault;

    modport master (
        input  run, instrData, stall, redirect, redirectAddr,
        output instrAddr, ir, irPc, irValid, halted, addrFault
    );

    modport slave (
        output run, instrData, stall, redirect, redirectAddr,
        input  instrAddr, ir, irPc, irValid, halted, addrFault
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads one 16-bit word per cycle
// from a combinational instruction memory into the IR, and handles stall,
// redirect/flush, halt-word detection and address faults.
module instr_fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int          MEM_WORDS = 30,
    parameter logic [15:0] HALT_WORD = 16'hEFFF
) (
    input logic             clk,
    input logic             reset,
    instr_fetch_unit_if.master bus
);

    localparam logic [15:0] LAST_ADDR = 16'(2 * MEM_WORDS - 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } stateT;

    stateT       state;
    stateT       nextState;
    logic [15:0] pc;
    logic [15:0] nextPc;
    logic [15:0] irReg;
    logic [15:0] nextIr;
    logic [15:0] irPcReg;
    logic [15:0] nextIrPc;
    logic        irValidReg;
    logic        nextIrValid;
    logic        faultReg;
    logic        nextFault;
    logic        redirectBad;

    // A redirect target is unusable if it is odd or past the last word.
    always_comb begin
        redirectBad = bus.redirectAddr[0] || (bus.redirectAddr > LAST_ADDR);
    end

    // State register; halt can only be left through reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Fetch datapath registers; irValid defaults low so it pulses per capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc         <= RESET_PC;
            irReg      <= 16'h0000;
            irPcReg    <= 16'h0000;
            irValidReg <= 1'b0;
            faultReg   <= 1'b0;
        end else begin
            pc         <= nextPc;
            irReg      <= nextIr;
            irPcReg    <= nextIrPc;
            irValidReg <= nextIrValid;
            faultReg   <= nextFault;
        end
    end

    // Next-state logic: redirect beats stall, stall beats run-drop, else capture.
    always_comb begin
        nextState   = state;
        nextPc      = pc;
        nextIr      = irReg;
        nextIrPc    = irPcReg;
        nextIrValid = 1'b0;
        nextFault   = faultReg;
        case (state)
            IDLE: begin
                if (bus.run) begin
                    nextState = FETCH;
                end
            end
            FETCH: begin
                if (bus.redirect) begin
                    if (redirectBad) begin
                        nextFault = 1'b1;
                        nextState = HALT;
                    end else begin
                        nextPc = bus.redirectAddr;
                    end
                end else if (bus.stall) begin
                    nextPc = pc;
                end else if (!bus.run) begin
                    nextState = IDLE;
                end else begin
                    nextIr      = bus.instrData;
                    nextIrPc    = pc;
                    nextIrValid = 1'b1;
                    if (bus.instrData == HALT_WORD) begin
                        nextState = HALT;
                    end else if (pc >= LAST_ADDR) begin
                        nextFault = 1'b1;
                        nextState = HALT;
                    end else begin
                        nextPc = pc + 16'd2;
                    end
                end
            end
            HALT: begin
                nextState = HALT;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    assign bus.instrAddr = pc;
    assign bus.ir        = irReg;
    assign bus.irPc      = irPcReg;
    assign bus.irValid   = irValidReg;
    assign bus.halted    = (state == HALT);
    assign bus.addrFault = faultReg;

endmodule
